// File: rtl/regwrite_pkg.sv
// Shared widths and the buffered write-back entry for the register write arbiter.
package regwrite_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 32;

  typedef struct packed {
    logic [REG_AW-1:0] idx;
    logic [XLEN-1:0]   data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// In-order buffer for long-latency results; pushes into a full FIFO and pops of an
// empty one are ignored, so callers may present raw requests.
module wb_fifo
  import regwrite_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  wb_entry_t     push_entry,
  input  logic          pop,
  output wb_entry_t     head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  wb_entry_t     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop_ok) count_d = count_q + CW'(1);
    else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: rtl/regwrite_arb.sv
// Single-port register-file write arbiter: ALU results win, buffered long-latency
// results drain in idle slots, and a busy scoreboard flags pending long writes.
module regwrite_arb
  import regwrite_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int HOLD_MARK  = FIFO_DEPTH - 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_dsel,
  input  logic [XLEN-1:0]   alu_d,
  input  logic              lng_valid,
  output logic              lng_ready,
  input  logic [REG_AW-1:0] lng_dsel,
  input  logic [XLEN-1:0]   lng_d,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_dsel,
  input  logic [REG_AW-1:0] chk1sel,
  input  logic [REG_AW-1:0] chk2sel,
  output logic              busy1,
  output logic              busy2,
  output logic              alu_hold,
  output logic              wen,
  output logic [REG_AW-1:0] dsel,
  output logic [XLEN-1:0]   d
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] HOLD_CNT = CW'(HOLD_MARK);

  wb_entry_t     head;
  logic          full, empty, push, pop;
  logic [CW-1:0] count, occ_d;

  logic [NREGS-1:0]  busy_q, busy_d;
  logic              wen_q, wen_d;
  logic [REG_AW-1:0] dsel_q, dsel_d;
  logic [XLEN-1:0]   d_q, d_d;
  logic              hold_q, hold_d;

  assign lng_ready = !full;
  assign push      = lng_valid && !full;
  assign pop       = !alu_valid && !empty;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .push       (push),
    .push_entry ('{idx: lng_dsel, data: lng_d}),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .count      (count)
  );

  always_comb begin
    occ_d = count;
    if (push && !pop) occ_d = count + CW'(1);
    else if (!push && pop) occ_d = count - CW'(1);
    hold_d = (occ_d >= HOLD_CNT);
  end

  // Index 0 is the hardwired zero register: the slot is consumed but nothing is written.
  always_comb begin
    wen_d  = 1'b0;
    dsel_d = dsel_q;
    d_d    = d_q;
    if (alu_valid) begin
      if (alu_dsel != '0) begin
        wen_d  = 1'b1;
        dsel_d = alu_dsel;
        d_d    = alu_d;
      end
    end else if (pop && head.idx != '0) begin
      wen_d  = 1'b1;
      dsel_d = head.idx;
      d_d    = head.data;
    end
  end

  // Clear on pop first so a same-cycle issue to that index leaves it busy.
  always_comb begin
    busy_d = busy_q;
    if (pop) busy_d[head.idx] = 1'b0;
    if (issue_valid && issue_dsel != '0) busy_d[issue_dsel] = 1'b1;
    busy_d[0] = 1'b0;
  end

  assign busy1    = busy_q[chk1sel];
  assign busy2    = busy_q[chk2sel];
  assign alu_hold = hold_q;
  assign wen      = wen_q;
  assign dsel     = dsel_q;
  assign d        = d_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy_q <= '0;
      wen_q  <= 1'b0;
      dsel_q <= '0;
      d_q    <= '0;
      hold_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      wen_q  <= wen_d;
      dsel_q <= dsel_d;
      d_q    <= d_d;
      hold_q <= hold_d;
    end
  end

endmodule

// File: doc/regwrite_arb.md
REGWRITE_ARB -- requirements
Module: regwrite_arb

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, entries in the long-latency result buffer (power of two, 2..16).
REQ-002 Parameter: HOLD_MARK, default FIFO_DEPTH-1, occupancy at or above which alu_hold asserts.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rstn  input  1  reset, synchronous and active-low.
REQ-005 alu_valid  input  1  single-cycle ALU result present this cycle; cannot be back-pressured in the same cycle.
REQ-006 alu_dsel  input  5  ALU destination register index.
REQ-007 alu_d  input  32  ALU result data.
REQ-008 lng_valid  input  1  long-latency (load/mul) result offered.
REQ-009 lng_ready  output  1  long-latency result accepted when lng_valid and lng_ready are both high.
REQ-010 lng_dsel  input  5  long-latency destination register index.
REQ-011 lng_d  input  32  long-latency result data.
REQ-012 issue_valid  input  1  a long-latency op is issued this cycle.
REQ-013 issue_dsel  input  5  destination of the issued long op.
REQ-014 chk1sel, chk2sel  input  5 each  source indices that the decoder checks for hazards.
REQ-015 busy1, busy2  output  1 each  the checked register has a pending long-latency write (combinational from the scoreboard).
REQ-016 alu_hold  output  1  registered; the upstream pipeline SHALL NOT present alu_valid on the cycle after alu_hold is high.
REQ-017 wen, dsel, d  output  1/5/32  registered write port to the register file.

Function
REQ-018 Each cycle at most one write SHALL be issued: ALU result if alu_valid, else the FIFO head if non-empty, else none.
REQ-019 Write latency SHALL be exactly one cycle: the winner's index/data appear on dsel/d with wen=1 on the next posedge.
REQ-020 Any write whose index is 0 SHALL be dropped (wen=0 that cycle); a dropped FIFO entry is still popped.
REQ-021 Accepted long results SHALL enter the FIFO in order; lng_ready = !full, and a same-cycle pop SHALL NOT make a full FIFO ready.
REQ-022 Simultaneous push and pop on a non-full FIFO SHALL keep occupancy unchanged; an empty FIFO SHALL never be popped.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy width SHALL be log2(FIFO_DEPTH)+1.
REQ-024 alu_hold SHALL be registered as (occupancy_next >= HOLD_MARK), guaranteeing a drain slot.
REQ-025 The scoreboard SHALL be a 32-bit busy vector; issue_valid with issue_dsel!=0 sets busy[issue_dsel].
REQ-026 A FIFO pop (write or drop) SHALL clear busy[popped index]; if the same index is set by an issue in that cycle, set SHALL win.
REQ-027 busy[0] SHALL always read 0; busy1/busy2 SHALL reflect the vector before the current cycle's update.
REQ-028 A pop whose index has busy=0 SHALL still write normally (no error state).

Reset
REQ-029 On a clk edge with rstn=0: wen=0, dsel=0, d=0, alu_hold=0, FIFO empty, pointers 0, busy vector all 0.
REQ-030 Reset mid-operation SHALL discard all buffered results with no write issued; lng_ready SHALL be 1 in the first cycle after reset.

Structure
REQ-031 Package regwrite_pkg SHALL hold XLEN=32, REG_AW=5, NREGS=32 and the FIFO entry type (index + data).
REQ-032 The FIFO SHALL be a separate sub-module wb_fifo (push/pop/full/empty/count); arbitration and scoreboard stay in regwrite_arb.

Verification
REQ-033 alu_valid=1, alu_dsel=5, alu_d=0x12345678 -> next cycle wen=1, dsel=5, d=0x12345678.
REQ-034 Issue dsel=6; lng result (6, 0xDEADBEEF) while no ALU -> busy for 6 high until pop; wen=1, dsel=6, d=0xDEADBEEF one cycle after accept; busy clears.
REQ-035 ALU valid every cycle, 4 lng results pushed -> lng_ready falls at full; alu_hold asserts at count 3; FIFO drains in order in held cycles.
REQ-036 alu_dsel=0 and lng_dsel=0 writes -> wen stays 0; FIFO entry still popped, count decrements.
REQ-037 Issue dsel=7 on the same cycle a result for 7 pops -> busy[7] remains 1.
REQ-038 rstn=0 with 3 entries buffered and busy bits set -> next cycle wen=0, all busy 0, lng_ready=1, no stale write after release.
